multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter OPCODE_W, default 6, is the opcode field width.
REQ-002 Parameter ALUOP_W, default 3, is the ALU operation code width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 opcode  in  OPCODE_W  opcode field of the instruction register; sampled in DECODE only.
REQ-006 mem_ready  in  1  memory completed the current request this cycle.
REQ-007 mem_req  out  1  memory request valid; held high until mem_ready.
REQ-008 mem_write  out  1  request is a write (valid only with mem_req).
REQ-009 i_or_d  out  1  memory address source: 0 = PC, 1 = ALU result.
REQ-010 ir_write  out  1  load instruction register.
REQ-011 pc_write  out  1  unconditional PC update.
REQ-012 branch  out  1  PC update qualified by ALU zero.
REQ-013 pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target.
REQ-014 alu_src_a  out  1  0 = PC, 1 = register A.
REQ-015 alu_src_b  out  2  0 = register B, 1 = constant 4, 2 = sign-extended immediate, 3 = shifted immediate.
REQ-016 alu_op  out  ALUOP_W  ADD, SUB or FUNCT (decode funct field).
REQ-017 reg_write, reg_dst, mem_to_reg, byte_op  out  1 each  register-file write, rd/rt destination select, memory-data writeback, byte-width access.
REQ-018 illegal  out  1  sticky flag: an unknown opcode was decoded.

Function
REQ-019 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-020 FETCH SHALL assert mem_req with i_or_d=0, alu_src_a=0, alu_src_b=1 and alu_op=ADD; while mem_ready=0 it SHALL hold all outputs and stay in FETCH.
REQ-021 In the mem_ready cycle, FETCH SHALL pulse ir_write and pc_write (pc_src=0) for that cycle only and go to DECODE.
REQ-022 DECODE SHALL compute the branch target (alu_src_a=0, alu_src_b=3, ADD), then branch on opcode: R/LW/LB/SW/SB/BEQ go to EXEC; J pulses pc_write with pc_src=2 and goes to FETCH; any other opcode goes to TRAP.
REQ-023 The opcode encodings SHALL be: R=000000, LW=001000, LB=001001, SW=100000, SB=100001, BEQ=100011, J=000010; LB/SB SHALL assert byte_op for the whole instruction.
REQ-024 EXEC for R-type SHALL drive alu_src_a=1, alu_src_b=0 and alu_op=FUNCT, then go to WB.
REQ-025 EXEC for loads and stores SHALL drive alu_src_a=1, alu_src_b=2 and alu_op=ADD, then go to MEM.
REQ-026 EXEC for BEQ SHALL drive alu_src_a=1, alu_src_b=0, alu_op=SUB, branch=1 and pc_src=1, then go to FETCH.
REQ-027 MEM SHALL assert mem_req with i_or_d=1, and mem_write=1 for stores; it SHALL hold until mem_ready, after which stores go to FETCH and loads go to WB.
REQ-028 WB SHALL pulse reg_write for one cycle, with reg_dst=1 and mem_to_reg=0 for R-type and reg_dst=0 and mem_to_reg=1 for loads, then go to FETCH.
REQ-029 TRAP SHALL set illegal, drive every strobe to 0 and remain in TRAP until reset.
REQ-030 Every output not listed for a state SHALL be 0 in that state; outputs are a Moore function of the registered state and latched opcode, except REQ-021/022 strobes, which depend on mem_ready/opcode in the same cycle.
REQ-031 Instruction latency with zero wait states SHALL be: R=4, LW/LB=5, SW/SB=4, BEQ=3 and J=2 cycles; each mem_ready wait cycle adds one cycle.
REQ-032 mem_ready asserted outside FETCH/MEM SHALL be ignored.

Reset
REQ-033 With reset high at a rising edge, the state SHALL become FETCH, the latched opcode 0 and illegal 0, regardless of the current state, including the middle of a MEM wait.
REQ-034 During reset and in the first FETCH cycle, all outputs SHALL be 0 except the FETCH defaults of REQ-020.

Structure
REQ-035 The state encoding, opcode constants and alu_op constants (ADD=000, SUB=001, FUNCT=111) SHALL live in a shared package, also used by the datapath and the combinational control unit.
REQ-036 An opcode decoder sub-module, cu_opcode_decode (opcode -> class one-hot plus byte_op/illegal), SHALL be instantiated once; the FSM and output logic SHALL remain in this module.

Verification
REQ-037 R-type, mem_ready=1 in FETCH -> states FETCH,DECODE,EXEC,WB; reg_write=1, reg_dst=1 exactly in cycle 4.
REQ-038 LB with two FETCH and three MEM wait cycles -> 10 cycles total; mem_req stays high through the waits; byte_op=1 throughout; mem_to_reg=1 in WB.
REQ-039 SB -> in MEM, mem_req=1, mem_write=1, i_or_d=1; return to FETCH with no reg_write pulse.
REQ-040 BEQ then J -> branch=1, pc_src=1, alu_op=001 in cycle 3; J gives pc_write=1, pc_src=2 in DECODE; next cycle is FETCH.
REQ-041 Opcode 111111 -> TRAP, illegal=1, all strobes 0 for 20 cycles; reset -> FETCH, illegal=0.
REQ-042 Reset asserted during a MEM wait of an SW -> no mem_write after reset; the next cycle is FETCH with i_or_d=0.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// rtl/multicycle_control_unit_pkg.sv - shared encodings for the multicycle control unit and datapath
package multicycle_control_unit_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b001000;
    localparam logic [5:0] OP_LB  = 6'b001001;
    localparam logic [5:0] OP_SW  = 6'b100000;
    localparam logic [5:0] OP_SB  = 6'b100001;
    localparam logic [5:0] OP_BEQ = 6'b100011;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_REG   = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_SHIFT = 2'd3;

    // one-hot instruction class produced by the opcode decoder
    typedef struct packed {
        logic r;
        logic ld;
        logic st;
        logic beq;
        logic j;
    } op_class_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - memory request/ready handshake between control unit and memory
interface multicycle_control_unit_if;
    logic mem_req;
    logic mem_write;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_write,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control_unit_opcode_decode.sv
// rtl/multicycle_control_unit_opcode_decode.sv - opcode to instruction class, byte width and illegal flag
module cu_opcode_decode
    import multicycle_control_unit_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           op_class,
    output logic                byte_op,
    output logic                illegal
);

    always_comb begin
        op_class = '0;
        byte_op  = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OPCODE_W'(OP_R):   op_class.r   = 1'b1;
            OPCODE_W'(OP_LW):  op_class.ld  = 1'b1;
            OPCODE_W'(OP_LB): begin
                op_class.ld = 1'b1;
                byte_op     = 1'b1;
            end
            OPCODE_W'(OP_SW):  op_class.st  = 1'b1;
            OPCODE_W'(OP_SB): begin
                op_class.st = 1'b1;
                byte_op     = 1'b1;
            end
            OPCODE_W'(OP_BEQ): op_class.beq = 1'b1;
            OPCODE_W'(OP_J):   op_class.j   = 1'b1;
            default:           illegal      = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle FSM sequencing fetch, decode, execute, memory and writeback
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [OPCODE_W-1:0]      opcode,
    multicycle_control_unit_if.master mem_bus,
    output logic                     i_or_d,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic                     branch,
    output logic [1:0]               pc_src,
    output logic                     alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [ALUOP_W-1:0]       alu_op,
    output logic                     reg_write,
    output logic                     reg_dst,
    output logic                     mem_to_reg,
    output logic                     byte_op,
    output logic                     illegal
);

    state_t              state;
    logic [OPCODE_W-1:0] op_q;
    logic [OPCODE_W-1:0] dec_opcode;
    op_class_t           cls;
    logic                dec_byte;
    logic                dec_illegal;
    logic                illegal_q;
    logic                mem_req_c;
    logic                mem_write_c;

    // The live opcode is only trusted in DECODE; later states use the copy latched there.
    assign dec_opcode = (state == DECODE) ? opcode : op_q;

    cu_opcode_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode   (dec_opcode),
        .op_class (cls),
        .byte_op  (dec_byte),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_bus.mem_ready) state <= DECODE;
                end
                DECODE: begin
                    op_q <= opcode;
                    if (dec_illegal) begin
                        state     <= TRAP;
                        illegal_q <= 1'b1;
                    end else if (cls.j) begin
                        state <= FETCH;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (cls.r)               state <= WB;
                    else if (cls.ld || cls.st) state <= MEM;
                    else                     state <= FETCH;
                end
                MEM: begin
                    if (mem_bus.mem_ready) state <= cls.st ? FETCH : WB;
                end
                WB:      state <= FETCH;
                TRAP:    state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        pc_src      = PC_SEQ;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        alu_op      = ALUOP_W'(ALU_ADD);
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        byte_op     = 1'b0;
        case (state)
            FETCH: begin
                mem_req_c = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            DECODE: begin
                alu_src_b = SRCB_SHIFT;
                byte_op   = dec_byte;
                if (cls.j) begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                end
            end
            EXEC: begin
                alu_src_a = 1'b1;
                byte_op   = dec_byte;
                if (cls.r) begin
                    alu_op = ALUOP_W'(ALU_FUNCT);
                end else if (cls.ld || cls.st) begin
                    alu_src_b = SRCB_IMM;
                end else if (cls.beq) begin
                    alu_op = ALUOP_W'(ALU_SUB);
                    branch = 1'b1;
                    pc_src = PC_BRANCH;
                end
            end
            MEM: begin
                mem_req_c   = 1'b1;
                mem_write_c = cls.st;
                i_or_d      = 1'b1;
                byte_op     = dec_byte;
            end
            WB: begin
                reg_write  = 1'b1;
                reg_dst    = cls.r;
                mem_to_reg = cls.ld;
                byte_op    = dec_byte;
            end
            default: begin
            end
        endcase
    end

    assign mem_bus.mem_req   = mem_req_c;
    assign mem_bus.mem_write = mem_write_c;
    assign illegal           = illegal_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for the multicycle control unit
module tb_multicycle_control_unit;

    localparam logic [5:0] R   = 6'b000000;
    localparam logic [5:0] LW  = 6'b001000;
    localparam logic [5:0] LB  = 6'b001001;
    localparam logic [5:0] SW  = 6'b100000;
    localparam logic [5:0] SB  = 6'b100001;
    localparam logic [5:0] BEQ = 6'b100011;
    localparam logic [5:0] J   = 6'b000010;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       byte_op;
        logic       illegal;
    } out_t;

    typedef struct {
        out_t  v;
        string tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       i_or_d, ir_write, pc_write, branch, alu_src_a;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write, reg_dst, mem_to_reg, byte_op, illegal;
    out_t       act;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    multicycle_control_unit_if mif ();

    multicycle_control_unit #(
        .OPCODE_W (6),
        .ALUOP_W  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_bus    (mif),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .branch     (branch),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .byte_op    (byte_op),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign act = {mif.mem_req, mif.mem_write, i_or_d, ir_write, pc_write, branch, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, byte_op, illegal};

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    function automatic out_t fetch_v(input logic rdy);
        out_t v = '0;
        v.mem_req   = 1'b1;
        v.alu_src_b = 2'd1;
        v.ir_write  = rdy;
        v.pc_write  = rdy;
        return v;
    endfunction

    function automatic out_t store_mem_v(input logic byt);
        out_t v = '0;
        v.mem_req   = 1'b1;
        v.mem_write = 1'b1;
        v.i_or_d    = 1'b1;
        v.byte_op   = byt;
        return v;
    endfunction

    // one clock cycle: drive inputs, record what the outputs must be in this cycle
    task automatic step(input logic rdy, input logic [5:0] opc, input out_t e, input string tag);
        exp_t x;
        mif.mem_ready = rdy;
        opcode        = opc;
        x.v           = e;
        x.tag         = tag;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour: the cycle-by-cycle output trace of one whole instruction.
    task automatic run_instr(input logic [5:0] opc, input int fw, input int mw);
        out_t v;
        logic byt;
        logic is_ld, is_st;
        byt   = (opc == LB) || (opc == SB);
        is_ld = (opc == LW) || (opc == LB);
        is_st = (opc == SW) || (opc == SB);
        for (int i = 0; i < fw; i++) step(1'b0, rnd6(), fetch_v(1'b0), "fetch_wait");
        step(1'b1, rnd6(), fetch_v(1'b1), "fetch");
        v = '0;
        v.alu_src_b = 2'd3;
        v.byte_op   = byt;
        if (opc == J) begin
            v.pc_write = 1'b1;
            v.pc_src   = 2'd2;
        end
        step(rnd1(), opc, v, "decode");
        if (opc == R) begin
            v = '0;
            v.alu_src_a = 1'b1;
            v.alu_op    = 3'b111;
            step(rnd1(), rnd6(), v, "exec_r");
            v = '0;
            v.reg_write = 1'b1;
            v.reg_dst   = 1'b1;
            step(rnd1(), rnd6(), v, "wb_r");
        end else if (is_ld || is_st) begin
            v = '0;
            v.alu_src_a = 1'b1;
            v.alu_src_b = 2'd2;
            v.byte_op   = byt;
            step(rnd1(), rnd6(), v, "exec_mem");
            v = '0;
            v.mem_req   = 1'b1;
            v.i_or_d    = 1'b1;
            v.mem_write = is_st;
            v.byte_op   = byt;
            for (int i = 0; i < mw; i++) step(1'b0, rnd6(), v, "mem_wait");
            step(1'b1, rnd6(), v, "mem");
            if (is_ld) begin
                v = '0;
                v.reg_write  = 1'b1;
                v.mem_to_reg = 1'b1;
                v.byte_op    = byt;
                step(rnd1(), rnd6(), v, "wb_load");
            end
        end else if (opc == BEQ) begin
            v = '0;
            v.alu_src_a = 1'b1;
            v.alu_op    = 3'b001;
            v.branch    = 1'b1;
            v.pc_src    = 2'd1;
            step(rnd1(), rnd6(), v, "exec_beq");
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.tag, act, e.v);
                end
            end
        end
    end

    initial begin : stimulus
        logic [5:0] legal[7];
        out_t       trap_v;
        out_t       v;
        legal = '{R, LW, LB, SW, SB, BEQ, J};

        reset         = 1'b1;
        mif.mem_ready = 1'b0;
        opcode        = '0;
        @(posedge clk);
        #1;
        step(1'b0, rnd6(), fetch_v(1'b0), "reset_state");
        step(1'b0, rnd6(), fetch_v(1'b0), "reset_state");
        reset = 1'b0;

        run_instr(R, 0, 0);
        run_instr(LB, 2, 3);
        run_instr(SB, 0, 1);
        run_instr(BEQ, 0, 0);
        run_instr(J, 0, 0);

        for (int n = 0; n < 60; n++)
            run_instr(legal[$urandom_range(0, 6)], $urandom_range(0, 3), $urandom_range(0, 3));

        // reset in the middle of a store's memory wait, with mem_ready raised in that same cycle
        step(1'b1, rnd6(), fetch_v(1'b1), "fetch");
        v = '0;
        v.alu_src_b = 2'd3;
        step(1'b0, SW, v, "decode_sw");
        v = '0;
        v.alu_src_a = 1'b1;
        v.alu_src_b = 2'd2;
        step(1'b0, rnd6(), v, "exec_sw");
        step(1'b0, rnd6(), store_mem_v(1'b0), "mem_wait_sw");
        step(1'b0, rnd6(), store_mem_v(1'b0), "mem_wait_sw");
        reset = 1'b1;
        step(1'b1, rnd6(), store_mem_v(1'b0), "mem_wait_reset");
        reset = 1'b0;
        step(1'b0, rnd6(), fetch_v(1'b0), "fetch_after_mem_reset");
        run_instr(SW, 0, 0);

        // illegal opcode locks into TRAP until reset
        trap_v = '0;
        trap_v.illegal = 1'b1;
        step(1'b1, rnd6(), fetch_v(1'b1), "fetch");
        v = '0;
        v.alu_src_b = 2'd3;
        step(1'b1, 6'b111111, v, "decode_illegal");
        for (int i = 0; i < 20; i++) step(rnd1(), rnd6(), trap_v, "trap");
        reset = 1'b1;
        step(1'b0, rnd6(), trap_v, "trap_in_reset");
        reset = 1'b0;
        step(1'b0, rnd6(), fetch_v(1'b0), "fetch_after_trap");
        run_instr(LW, 1, 1);

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
